// File: rtl/ks_adder_pipe.sv
// rtl/ks_adder_pipe.sv - pipelined Kogge-Stone adder with valid/ready flow control
// Stages: pre (p/g), log2(WIDTH) prefix levels, post (sum/cout); one global stall.
module ks_adder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LVL = $clog2(WIDTH);
  localparam int N   = LVL + 2;

  // Group propagate is not needed after the last prefix level, so p stops one short.
  logic [LVL-1:0][WIDTH-1:0] p_q, p_d;
  logic [LVL:0][WIDTH-1:0]   g_q, g_d;
  logic [LVL:0][WIDTH-1:0]   rp_q, rp_d;
  logic [LVL:0]              ci_q, ci_d;
  logic [N-1:0]              v_q, v_d;
  logic [WIDTH-1:0]          sum_q, sum_d;
  logic                      cout_q, cout_d;
  logic                      stall;

  function automatic logic [WIDTH-1:0] lo_mask(input int d);
    lo_mask = (WIDTH'(1) << d) - WIDTH'(1);
  endfunction

  assign stall     = v_q[N-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v_q[N-1];
  assign sum       = sum_q;
  assign cout      = cout_q;

  always_comb begin
    p_d     = p_q;
    g_d     = g_q;
    rp_d    = rp_q;
    ci_d    = ci_q;
    p_d[0]  = a ^ b;
    g_d[0]  = a & b;
    g_d[0][0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
    rp_d[0] = a ^ b;
    ci_d[0] = cin;
    for (int k = 1; k < LVL; k++) begin
      p_d[k] = p_q[k-1] & ((p_q[k-1] << (1 << (k-1))) | lo_mask(1 << (k-1)));
    end
    // Shifting in zeros leaves the low d bits of G untouched: those are the buffer slots.
    for (int k = 1; k <= LVL; k++) begin
      g_d[k]  = g_q[k-1] | (p_q[k-1] & (g_q[k-1] << (1 << (k-1))));
      rp_d[k] = rp_q[k-1];
      ci_d[k] = ci_q[k-1];
    end
    sum_d  = rp_q[LVL] ^ {g_q[LVL][WIDTH-2:0], ci_q[LVL]};
    cout_d = g_q[LVL][WIDTH-1];
    v_d    = {v_q[N-2:0], in_valid & in_ready};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= '0;
      g_q    <= '0;
      rp_q   <= '0;
      ci_q   <= '0;
      v_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (!stall) begin
      p_q    <= p_d;
      g_q    <= g_d;
      rp_q   <= rp_d;
      ci_q   <= ci_d;
      v_q    <= v_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

endmodule
